// File: rtl/reram_pkg.sv
// Shared definitions for the 8x8 ReRAM crossbar sequencer.
// Contents: crossbar geometry and lane widths, the controller state enum,
// packed lane vector types and the per-lane saturation helper.
package reram_pkg;

    localparam int XBAR_N     = 8;
    localparam int XBAR_CELLS = 64;
    localparam int V_W        = 8;
    localparam int G_W        = 8;
    localparam int I_W        = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PROG   = 2'd1,
        SETTLE = 2'd2,
        OUT    = 2'd3
    } mvm_state_e;

    typedef logic [XBAR_N-1:0][V_W-1:0] volt_vec_t;
    typedef logic [XBAR_N-1:0][I_W-1:0] curr_vec_t;

    // Unsigned per-lane min(lane, ceil).
    function automatic curr_vec_t clamp_lanes(input curr_vec_t lanes,
                                              input logic [I_W-1:0] ceil);
        curr_vec_t res;
        for (int i = 0; i < XBAR_N; i++) begin
            res[i] = (lanes[i] > ceil) ? ceil : lanes[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/reram_crossbar_8x8.sv
// Behavioural 8x8 ReRAM crossbar used alongside reram_mvm_ctrl.
// Ports:
//   clk, rst_n        clock, synchronous active-low clear of all cells
//   prog_enable/addr/data  cell write port (one cell per cycle)
//   voltages_packed   8 column voltages, lane c at [c*8+:8]
//   currents_packed   8 row currents, row r at [r*32+:32], combinational
//                     sum over c of V[c]*G[r*8+c]
module reram_crossbar_8x8
    import reram_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         prog_enable,
    input  logic [5:0]   prog_addr,
    input  logic [7:0]   prog_data,
    input  logic [63:0]  voltages_packed,
    output logic [255:0] currents_packed
);

    logic [G_W-1:0] g_q [XBAR_CELLS];
    volt_vec_t      volt;
    curr_vec_t      cur;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < XBAR_CELLS; i++) begin
                g_q[i] <= '0;
            end
        end else if (prog_enable) begin
            g_q[prog_addr] <= prog_data;
        end
    end

    assign volt = volt_vec_t'(voltages_packed);

    always_comb begin
        cur = '0;
        for (int r = 0; r < XBAR_N; r++) begin
            for (int c = 0; c < XBAR_N; c++) begin
                cur[r] = cur[r] + (32'(volt[c]) * 32'(g_q[r*XBAR_N+c]));
            end
        end
    end

    assign currents_packed = cur;

endmodule

// File: rtl/reram_mvm_ctrl.sv
// Sequencer for the 8x8 ReRAM crossbar: streams a 64-entry conductance
// matrix into the array, then runs one matrix-vector multiply at a time
// (drive voltages, wait settle time, capture row currents, hand off result).
// Optional build macro: RERAM_MVM_CLAMP_EN saturates each captured lane
// at CLAMP_MAX; without it lanes are captured raw.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   w_valid/w_ready/w_data weight stream, row-major index r*8+c
//   x_valid/x_ready/x_data input vector, lane c at [c*8+:8]
//   y_valid/y_ready/y_data result, row r at [r*32+:32]
//   weights_loaded         full matrix has been programmed
//   prog_enable/addr/data  crossbar cell write port
//   voltages_packed        registered crossbar drive voltages
//   currents_packed        crossbar row currents
module reram_mvm_ctrl
    import reram_pkg::*;
#(
    parameter int          N             = 8,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] CLAMP_MAX     = 32'd65535
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         w_valid,
    output logic         w_ready,
    input  logic [7:0]   w_data,
    input  logic         x_valid,
    output logic         x_ready,
    input  logic [63:0]  x_data,
    output logic         y_valid,
    input  logic         y_ready,
    output logic [255:0] y_data,
    output logic         weights_loaded,
    output logic         prog_enable,
    output logic [5:0]   prog_addr,
    output logic [7:0]   prog_data,
    output logic [63:0]  voltages_packed,
    input  logic [255:0] currents_packed
);

`ifdef RERAM_MVM_CLAMP_EN
    localparam logic CLAMP_ON = 1'b1;
`else
    localparam logic CLAMP_ON = 1'b0;
`endif

    localparam logic [5:0] W_LAST = 6'(N*N-1);
    localparam logic [3:0] S_LAST = 4'(SETTLE_CYCLES-1);

    mvm_state_e state_q;
    logic [5:0] wcnt_q;
    logic [3:0] scnt_q;
    logic       wl_q;
    logic       y_valid_q;
    volt_vec_t  volt_q;
    curr_vec_t  y_data_q;
    curr_vec_t  cur_raw;
    curr_vec_t  cur_cap;

    assign cur_raw = curr_vec_t'(currents_packed);
    assign cur_cap = CLAMP_ON ? clamp_lanes(cur_raw, CLAMP_MAX) : cur_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            scnt_q    <= '0;
            wl_q      <= 1'b0;
            y_valid_q <= 1'b0;
            volt_q    <= '0;
            y_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The entry cycle only switches modes; the first weight
                    // is taken on the following PROG cycle.
                    if (w_valid) begin
                        state_q <= PROG;
                        wl_q    <= 1'b0;
                        wcnt_q  <= '0;
                    end else if (x_valid) begin
                        volt_q  <= volt_vec_t'(x_data);
                        scnt_q  <= '0;
                        state_q <= SETTLE;
                    end
                end
                PROG: begin
                    if (w_valid) begin
                        if (wcnt_q == W_LAST) begin
                            wcnt_q  <= '0;
                            wl_q    <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            wcnt_q <= wcnt_q + 6'd1;
                        end
                    end
                end
                SETTLE: begin
                    if (scnt_q == S_LAST) begin
                        y_data_q  <= cur_cap;
                        y_valid_q <= 1'b1;
                        state_q   <= OUT;
                    end else begin
                        scnt_q <= scnt_q + 4'd1;
                    end
                end
                OUT: begin
                    if (y_ready) begin
                        y_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_ready         = (state_q == IDLE) || (state_q == PROG);
    assign x_ready         = (state_q == IDLE);
    assign prog_enable     = (state_q == PROG) && w_valid;
    assign prog_addr       = wcnt_q;
    assign prog_data       = w_data;
    assign weights_loaded  = wl_q;
    assign y_valid         = y_valid_q;
    assign y_data          = y_data_q;
    assign voltages_packed = volt_q;

endmodule

// File: tb/tb_reram_mvm_ctrl.sv
// Directed bench for reram_mvm_ctrl driving a behavioural crossbar.
// Expected results come from a local conductance model and are queued
// when each vector is issued, then popped at the result handshake.
module tb_reram_mvm_ctrl;

    localparam int SETTLE = 2;
`ifdef RERAM_MVM_CLAMP_EN
    localparam logic [31:0] CAP = 32'd65535;
`else
    localparam logic [31:0] CAP = 32'hFFFF_FFFF;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         w_valid = 1'b0;
    logic         w_ready;
    logic [7:0]   w_data = '0;
    logic         x_valid = 1'b0;
    logic         x_ready;
    logic [63:0]  x_data = '0;
    logic         y_valid;
    logic         y_ready = 1'b0;
    logic [255:0] y_data;
    logic         weights_loaded;
    logic         prog_enable;
    logic [5:0]   prog_addr;
    logic [7:0]   prog_data;
    logic [63:0]  voltages_packed;
    logic [255:0] currents_packed;

    always #5 clk = ~clk;

    reram_mvm_ctrl #(.N(8), .SETTLE_CYCLES(SETTLE), .CLAMP_MAX(32'd65535)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
        .weights_loaded(weights_loaded),
        .prog_enable(prog_enable), .prog_addr(prog_addr), .prog_data(prog_data),
        .voltages_packed(voltages_packed), .currents_packed(currents_packed)
    );

    reram_crossbar_8x8 xbar (
        .clk(clk), .rst_n(~rst),
        .prog_enable(prog_enable), .prog_addr(prog_addr), .prog_data(prog_data),
        .voltages_packed(voltages_packed), .currents_packed(currents_packed)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]   g_model [64];
    logic [255:0] sb [$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] model(input logic [63:0] v);
        logic [255:0] res;
        logic [31:0]  acc;
        res = '0;
        for (int r = 0; r < 8; r++) begin
            acc = '0;
            for (int c = 0; c < 8; c++) begin
                acc = acc + 32'(v[c*8+:8]) * 32'(g_model[r*8+c]);
            end
            if (acc > CAP) acc = CAP;
            res[r*32+:32] = acc;
        end
        return res;
    endfunction

    function automatic logic [255:0] lanes_const(input logic [31:0] base, input bit scale);
        logic [255:0] res;
        for (int r = 0; r < 8; r++) begin
            res[r*32+:32] = scale ? base * 32'(r + 1) : base;
        end
        return res;
    endfunction

    // kind 0 = identity (0xFF diagonal), 1 = all 0xFF, other = weight k = k
    task automatic load_matrix(input int kind, input bit throttle);
        logic [7:0] w [64];
        int  idx, cyc, pulses;
        bit  tog;
        for (int k = 0; k < 64; k++) begin
            case (kind)
                0:       w[k] = ((k / 8) == (k % 8)) ? 8'hFF : 8'h00;
                1:       w[k] = 8'hFF;
                default: w[k] = 8'(k);
            endcase
        end
        w_valid = 1'b1;
        w_data  = w[0];
        #1;
        chk("idle_prog_enable", {255'd0, prog_enable}, 256'd0);
        tick();
        chk("prog_w_ready", {255'd0, w_ready}, 256'd1);
        chk("prog_x_ready", {255'd0, x_ready}, 256'd0);
        chk("wl_cleared", {255'd0, weights_loaded}, 256'd0);
        idx = 0; cyc = 0; pulses = 0; tog = 1'b1;
        while (idx < 64 && cyc < 400) begin
            w_valid = throttle ? tog : 1'b1;
            w_data  = w[idx];
            #1;
            chk("prog_enable", {255'd0, prog_enable}, {255'd0, w_valid});
            if (prog_enable) begin
                pulses++;
                chk("prog_addr", {250'd0, prog_addr}, 256'(idx));
                chk("prog_data", {248'd0, prog_data}, {248'd0, w[idx]});
            end
            @(posedge clk);
            #1;
            if (w_valid) begin
                g_model[idx] = w[idx];
                idx++;
            end
            tog = ~tog;
            cyc++;
        end
        w_valid = 1'b0;
        chk("load_count", 256'(idx), 256'd64);
        chk("prog_pulses", 256'(pulses), 256'd64);
        chk("wl_set", {255'd0, weights_loaded}, 256'd1);
        chk("post_load_x_ready", {255'd0, x_ready}, 256'd1);
    endtask

    task automatic run_mvm(input logic [63:0] v, input int hold, output logic [255:0] y_seen);
        logic [255:0] exp_y, held;
        int  cyc, n;
        bit  acc;
        x_valid = 1'b1;
        x_data  = v;
        sb.push_back(model(v));
        cyc = 0; acc = 1'b0;
        while (!acc && cyc < 100) begin
            #1;
            acc = x_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("x_accepted", {255'd0, acc}, 256'd1);
        x_valid = 1'b0;
        chk("volt_reg", {192'd0, voltages_packed}, {192'd0, v});
        n = 0;
        while (!y_valid && n < 50) begin
            tick();
            n++;
        end
        chk("y_latency", 256'(n), 256'(SETTLE));
        held = y_data;
        if (hold > 0) begin
            x_valid = 1'b1;
            x_data  = ~v;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("bp_y_valid", {255'd0, y_valid}, 256'd1);
            chk("bp_y_data", y_data, held);
            chk("bp_x_ready", {255'd0, x_ready}, 256'd0);
            chk("bp_volt", {192'd0, voltages_packed}, {192'd0, v});
        end
        x_valid = 1'b0;
        y_ready = 1'b1;
        #1;
        y_seen = y_data;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 256'd0, 256'd1);
        end else begin
            exp_y = sb.pop_front();
            chk("y_data", y_data, exp_y);
        end
        tick();
        y_ready = 1'b0;
        chk("y_drop", {255'd0, y_valid}, 256'd0);
        chk("x_ready_back", {255'd0, x_ready}, 256'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] y_seen;
        logic [63:0]  v_ramp;
        for (int c = 0; c < 8; c++) v_ramp[c*8+:8] = 8'(c + 1);
        for (int k = 0; k < 64; k++) g_model[k] = 8'h00;

        // reset state
        tick();
        tick();
        chk("rst_y_valid", {255'd0, y_valid}, 256'd0);
        chk("rst_wl", {255'd0, weights_loaded}, 256'd0);
        chk("rst_y_data", y_data, 256'd0);
        chk("rst_volt", {192'd0, voltages_packed}, 256'd0);
        chk("rst_prog_enable", {255'd0, prog_enable}, 256'd0);
        rst = 1'b0;
        #1;
        chk("rst_x_ready", {255'd0, x_ready}, 256'd1);
        chk("rst_w_ready", {255'd0, w_ready}, 256'd1);

        // identity matrix, ramp vector
        load_matrix(0, 1'b0);
        run_mvm(v_ramp, 0, y_seen);
        chk("identity_lanes", y_seen, lanes_const(32'd255, 1'b1));
        chk("identity_wl", {255'd0, weights_loaded}, 256'd1);

        // all-ones saturation with result backpressure
        load_matrix(1, 1'b0);
        run_mvm({8{8'hFF}}, 5, y_seen);
`ifdef RERAM_MVM_CLAMP_EN
        chk("sat_lanes", y_seen, lanes_const(32'd65535, 1'b0));
`else
        chk("sat_lanes", y_seen, lanes_const(32'd520200, 1'b0));
`endif

        // throttled load, weight k = k, unit vector on lane 0
        load_matrix(2, 1'b1);
        run_mvm(64'h1, 0, y_seen);
        chk("throttle_lanes", y_seen, {32'd56, 32'd48, 32'd40, 32'd32, 32'd24, 32'd16, 32'd8, 32'd0});

        // reset in the middle of a load
        w_valid = 1'b1;
        for (int k = 0; k < 11; k++) begin
            w_data = 8'(k + 1);
            tick();
        end
        chk("midprog_enable", {255'd0, prog_enable}, 256'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        w_valid = 1'b0;
        #1;
        for (int k = 0; k < 64; k++) g_model[k] = 8'h00;
        chk("abort_wl", {255'd0, weights_loaded}, 256'd0);
        chk("abort_prog_enable", {255'd0, prog_enable}, 256'd0);
        chk("abort_x_ready", {255'd0, x_ready}, 256'd1);
        chk("abort_y_valid", {255'd0, y_valid}, 256'd0);
        run_mvm({8{8'hFF}}, 0, y_seen);
        chk("cleared_xbar", y_seen, 256'd0);
        load_matrix(0, 1'b0);
        run_mvm(v_ramp, 0, y_seen);
        chk("reload_identity", y_seen, lanes_const(32'd255, 1'b1));

        // weight stream wins over a simultaneous vector
        x_valid = 1'b1;
        x_data  = {8{8'd2}};
        load_matrix(1, 1'b0);
        chk("prio_volt_untouched", {192'd0, voltages_packed}, {192'd0, v_ramp});
        run_mvm({8{8'd2}}, 0, y_seen);
        chk("prio_lanes", y_seen, lanes_const(32'd4080, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
